counter_rr_scheduler: RTL and testbench

- Shares one WIDTH-bit up-counter between NUM_REQ requesters.
- Each requester asks for a counting session with its own terminal count. A round-robin arbiter picks one requester, and the counter runs from 0 up to that requester's target. The block then pulses a per-requester done and releases the counter.
- Sits between the counter-benchmark datapath and the client blocks that need timed intervals.

---
 rtl/counter_rr_scheduler.sv | 114 +++++++++++
 tb/tb_counter_rr_scheduler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_rr_scheduler.sv
// Round-robin scheduler sharing one up-counter between NUM_REQ requesters.
// The winner's target is latched at grant; a done pulse closes each completed session.
module counter_rr_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] target,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [WIDTH-1:0]         count
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              r_state;
  logic [IdxW-1:0]     r_last;
  logic [IdxW-1:0]     r_owner;
  logic [WIDTH-1:0]    r_tgt;
  logic [WIDTH-1:0]    r_count;
  logic [NUM_REQ-1:0]  r_grant;
  logic [NUM_REQ-1:0]  r_done;
  logic                r_busy;

  logic [IdxW-1:0]     w_winner;
  logic [IdxW-1:0]     w_cand;
  logic                w_found;
  int unsigned         w_sum;
  logic [NUM_REQ-1:0]  w_winner_oh;
  logic [WIDTH-1:0]    w_tgt_arr [NUM_REQ];

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_tgt_arr[i] = target[i*WIDTH +: WIDTH];
    end
  end

  // Search starts just past the previous winner so the last owner ranks lowest.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_last;
    w_cand   = r_last;
    w_sum    = 0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      w_sum  = (32'(r_last) + off) % NUM_REQ;
      w_cand = w_sum[IdxW-1:0];
      if (!w_found && req[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  assign w_winner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_winner;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_last  <= IdxW'(NUM_REQ - 1);
      r_owner <= '0;
      r_tgt   <= '0;
      r_count <= '0;
      r_grant <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_found) begin
            r_state <= StRun;
            r_owner <= w_winner;
            r_grant <= w_winner_oh;
            r_tgt   <= w_tgt_arr[w_winner];
            r_count <= '0;
            r_busy  <= 1'b1;
          end
        end
        StRun: begin
          // Abort outranks completion; count is frozen either way.
          if (!req[r_owner]) begin
            r_state <= StIdle;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_last  <= r_owner;
          end else if (r_count == r_tgt) begin
            r_state <= StDone;
            r_done  <= r_grant;
          end else begin
            r_count <= r_count + WIDTH'(1);
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_done  <= '0;
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_last  <= r_owner;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign grant = r_grant;
  assign done  = r_done;
  assign busy  = r_busy;
  assign count = r_count;

endmodule

// File: tb/tb_counter_rr_scheduler.sv
// Directed bench for counter_rr_scheduler with hand-derived per-cycle expectations.
// A second 8-bit instance covers the all-ones target without wrap.
module tb_counter_rr_scheduler;

  logic          clk;
  logic          reset;
  logic [3:0]    req;
  logic [127:0]  target;
  logic [3:0]    grant;
  logic [3:0]    done;
  logic          busy;
  logic [31:0]   count;

  logic [3:0]    req8;
  logic [31:0]   target8;
  logic [3:0]    grant8;
  logic [3:0]    done8;
  logic          busy8;
  logic [7:0]    count8;

  int n_checks;
  int n_errors;

  counter_rr_scheduler #(.NUM_REQ(4), .WIDTH(32)) u_dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .target (target),
    .grant  (grant),
    .done   (done),
    .busy   (busy),
    .count  (count)
  );

  counter_rr_scheduler #(.NUM_REQ(4), .WIDTH(8)) u_dut8 (
    .clk    (clk),
    .reset  (reset),
    .req    (req8),
    .target (target8),
    .grant  (grant8),
    .done   (done8),
    .busy   (busy8),
    .count  (count8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sample point for cycle k is just after edge k; inputs set here are seen at edge k+1.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    req      = '0;
    target   = '0;
    req8     = '0;
    target8  = '0;
    tick();
    tick();
    check_eq("rst grant", 64'(grant), 64'h0);
    check_eq("rst done", 64'(done), 64'h0);
    check_eq("rst busy", 64'(busy), 64'h0);
    check_eq("rst count", 64'(count), 64'h0);
    check_eq("rst count8", 64'(count8), 64'h0);

    // Single request, target 5
    reset = 1'b0;
    req = 4'b0001;
    target[0 +: 32] = 32'd5;
    for (int c = 1; c <= 8; c++) begin
      tick();
      check_eq($sformatf("t1 grant c%0d", c), 64'(grant), (c <= 7) ? 64'h1 : 64'h0);
      check_eq($sformatf("t1 count c%0d", c), 64'(count), (c <= 6) ? 64'(c - 1) : 64'd5);
      check_eq($sformatf("t1 done c%0d", c), 64'(done), (c == 7) ? 64'h1 : 64'h0);
      check_eq($sformatf("t1 busy c%0d", c), 64'(busy), (c <= 7) ? 64'h1 : 64'h0);
      if (c == 7) req = 4'b0000;
    end

    // Round robin, all targets 2, 5-cycle sessions
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 4'b1111;
    target = {4{32'd2}};
    for (int c = 1; c <= 25; c++) begin
      int ph;
      int s;
      logic [63:0] oh;
      tick();
      ph = (c - 1) % 5;
      s  = (c - 1) / 5;
      oh = 64'h1 << (s % 4);
      check_eq($sformatf("rr grant c%0d", c), 64'(grant), (ph <= 3) ? oh : 64'h0);
      check_eq($sformatf("rr done c%0d", c), 64'(done), (ph == 3) ? oh : 64'h0);
      check_eq($sformatf("rr count c%0d", c), 64'(count), (ph <= 2) ? 64'(ph) : 64'd2);
      check_eq($sformatf("rr busy c%0d", c), 64'(busy), (ph <= 3) ? 64'h1 : 64'h0);
    end
    req = 4'b0000;

    // Target 0: one RUN cycle, done in cycle 2
    tick();
    req = 4'b0001;
    target[0 +: 32] = 32'd0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check_eq($sformatf("z grant c%0d", c), 64'(grant), (c <= 2) ? 64'h1 : 64'h0);
      check_eq($sformatf("z done c%0d", c), 64'(done), (c == 2) ? 64'h1 : 64'h0);
      check_eq($sformatf("z count c%0d", c), 64'(count), 64'h0);
      if (c == 2) req = 4'b0000;
    end

    // All-ones target on the 8-bit instance
    req8 = 4'b0001;
    target8[7:0] = 8'hFF;
    for (int c = 1; c <= 258; c++) begin
      tick();
      if (c == 255) begin
        check_eq("max count c255", 64'(count8), 64'hFE);
        check_eq("max done c255", 64'(done8), 64'h0);
      end
      if (c == 256) begin
        check_eq("max count c256", 64'(count8), 64'hFF);
        check_eq("max done c256", 64'(done8), 64'h0);
      end
      if (c == 257) begin
        check_eq("max done c257", 64'(done8), 64'h1);
        check_eq("max count c257", 64'(count8), 64'hFF);
        req8 = 4'b0000;
      end
      if (c == 258) begin
        check_eq("max count c258", 64'(count8), 64'hFF);
        check_eq("max grant c258", 64'(grant8), 64'h0);
        check_eq("max done c258", 64'(done8), 64'h0);
      end
    end

    // Abort at count 4, then requester 0 wins over 1
    req = 4'b0010;
    target[32 +: 32] = 32'd10;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) check_eq("ab grant c1", 64'(grant), 64'h2);
      if (c == 5) begin
        check_eq("ab count c5", 64'(count), 64'd4);
        req = 4'b0000;
      end
      if (c == 6) begin
        check_eq("ab grant c6", 64'(grant), 64'h0);
        check_eq("ab busy c6", 64'(busy), 64'h0);
      end
      if (c >= 6) begin
        check_eq($sformatf("ab done c%0d", c), 64'(done), 64'h0);
        check_eq($sformatf("ab count c%0d", c), 64'(count), 64'd4);
      end
    end
    req = 4'b0011;
    tick();
    check_eq("ab grant c9", 64'(grant), 64'h1);
    tick();
    check_eq("ab done c10", 64'(done), 64'h1);
    tick();
    check_eq("ab grant c11", 64'(grant), 64'h0);
    tick();
    check_eq("ab grant c12", 64'(grant), 64'h2);
    req = 4'b0000;
    tick();

    // Latched target ignores later changes; late request waits its turn
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 4'b0001;
    target[0 +: 32]  = 32'd6;
    target[64 +: 32] = 32'd20;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) check_eq("lt grant c1", 64'(grant), 64'h1);
      if (c == 2) begin
        check_eq("lt grant c2", 64'(grant), 64'h1);
        target[0 +: 32] = 32'd1;
        req = 4'b0101;
      end
      if (c == 3) check_eq("lt done c3", 64'(done), 64'h0);
      if (c == 7) begin
        check_eq("lt count c7", 64'(count), 64'd6);
        check_eq("lt done c7", 64'(done), 64'h0);
      end
      if (c == 8) begin
        check_eq("lt done c8", 64'(done), 64'h1);
        check_eq("lt grant c8", 64'(grant), 64'h1);
        req = 4'b0100;
      end
      if (c == 9) begin
        check_eq("lt grant c9", 64'(grant), 64'h0);
        check_eq("lt done c9", 64'(done), 64'h0);
      end
      if (c == 10) begin
        check_eq("lt grant c10", 64'(grant), 64'h4);
        check_eq("lt count c10", 64'(count), 64'h0);
      end
    end

    // Synchronous reset mid-RUN at count 3
    tick();
    tick();
    tick();
    check_eq("sr count pre", 64'(count), 64'd3);
    reset = 1'b1;
    #2;
    check_eq("sr count noedge", 64'(count), 64'd3);
    check_eq("sr grant noedge", 64'(grant), 64'h4);
    check_eq("sr busy noedge", 64'(busy), 64'h1);
    tick();
    check_eq("sr grant", 64'(grant), 64'h0);
    check_eq("sr done", 64'(done), 64'h0);
    check_eq("sr busy", 64'(busy), 64'h0);
    check_eq("sr count", 64'(count), 64'h0);
    reset = 1'b0;
    req = 4'b0000;
    tick();
    check_eq("sr done after", 64'(done), 64'h0);
    check_eq("sr grant after", 64'(grant), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
